// File: rtl/sdram_sched_if.sv
// Bundles for the scheduler: the three-channel requester side and the
// single SDRAM controller command port.
interface sdram_req_if #(
  parameter int ADDR_BITS = 22
);
  logic [2:0]             req;
  logic [2:0]             we;
  logic [3*ADDR_BITS-1:0] addr;
  logic [47:0]            wdata;
  logic [5:0]             wmask;
  logic [2:0]             ack;
  logic [2:0]             rvalid;
  logic [15:0]            rdata;

  modport master (output req, we, addr, wdata, wmask, input ack, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output ack, rvalid, rdata);
endinterface

interface sdram_mem_if #(
  parameter int ADDR_BITS = 22
);
  logic                 mem_req;
  logic                 mem_refresh;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [15:0]          mem_wdata;
  logic [1:0]           mem_wmask;
  logic                 mem_ready;
  logic                 mem_rvalid;
  logic [15:0]          mem_rdata;

  modport master (output mem_req, mem_refresh, mem_we, mem_addr, mem_wdata, mem_wmask,
                  input  mem_ready, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_refresh, mem_we, mem_addr, mem_wdata, mem_wmask,
                  output mem_ready, mem_rvalid, mem_rdata);
endinterface

// File: rtl/sdram_sched.sv
// Fixed-priority scheduler of three SDRAM requesters onto one controller port,
// one access outstanding, with owed-refresh bookkeeping and forced refresh.
module sdram_sched #(
  parameter int ADDR_BITS        = 22,
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_OWED         = 8
) (
  input  logic        clk,
  input  logic        async_nreset,
  input  logic        refresh_hint,
  sdram_req_if.slave  rq,
  sdram_mem_if.master mem
);

  localparam int CNT_W  = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int OWED_W = $clog2(MAX_OWED + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, REF} state_t;

  state_t            state;
  logic [CNT_W-1:0]  int_cnt;
  logic [OWED_W-1:0] owed;
  logic [1:0]        owner;

  logic [1:0] pick;
  logic       tick;
  logic       ref_done;
  logic       owed_full;

  always_comb begin
    // NOTE: default assignment first so every path drives pick and no latch is inferred.
    pick = 2'd0;
    if (rq.req[0])      pick = 2'd0;
    else if (rq.req[1]) pick = 2'd1;
    else if (rq.req[2]) pick = 2'd2;
  end

  assign tick      = (int_cnt == CNT_W'(REFRESH_INTERVAL - 1));
  assign ref_done  = (state == REF) && mem.mem_ready;
  assign owed_full = (owed == OWED_W'(MAX_OWED));

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      state           <= IDLE;
      int_cnt         <= '0;
      owed            <= '0;
      owner           <= '0;
      mem.mem_req     <= 1'b0;
      mem.mem_refresh <= 1'b0;
      mem.mem_we      <= 1'b0;
      mem.mem_addr    <= '0;
      mem.mem_wdata   <= '0;
      mem.mem_wmask   <= '0;
      rq.ack          <= '0;
      rq.rvalid       <= '0;
      rq.rdata        <= '0;
    end else begin
      rq.ack    <= '0;
      rq.rvalid <= '0;

      int_cnt <= tick ? '0 : int_cnt + CNT_W'(1);

      // A wrap and a refresh acceptance in the same cycle cancel out.
      if (tick && !ref_done && !owed_full)
        owed <= owed + OWED_W'(1);
      else if (!tick && ref_done)
        owed <= owed - OWED_W'(1);

      case (state)
        IDLE: begin
          if (owed_full || (refresh_hint && owed != '0)) begin
            mem.mem_refresh <= 1'b1;
            state           <= REF;
          end else if (|rq.req) begin
            owner         <= pick;
            mem.mem_we    <= rq.we[pick];
            mem.mem_addr  <= rq.addr[int'(pick)*ADDR_BITS +: ADDR_BITS];
            mem.mem_wdata <= rq.wdata[int'(pick)*16 +: 16];
            mem.mem_wmask <= rq.wmask[int'(pick)*2 +: 2];
            mem.mem_req   <= 1'b1;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          if (mem.mem_ready) begin
            mem.mem_req <= 1'b0;
            rq.ack      <= 3'b001 << owner;
            state       <= mem.mem_we ? IDLE : RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (mem.mem_rvalid) begin
            rq.rdata  <= mem.mem_rdata;
            rq.rvalid <= 3'b001 << owner;
            state     <= IDLE;
          end
        end

        REF: begin
          if (mem.mem_ready) begin
            mem.mem_refresh <= 1'b0;
            state           <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_sched.sv
// Self-checking bench for sdram_sched: directed scenarios plus a randomized
// run scored against a transaction-level model of arbitration and refresh debt.
module tb_sdram_sched;

  localparam int AB  = 22;
  localparam int RI  = 16;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic async_nreset;
  logic refresh_hint;

  sdram_req_if #(.ADDR_BITS(AB)) ri ();
  sdram_mem_if #(.ADDR_BITS(AB)) mi ();

  sdram_sched #(.ADDR_BITS(AB), .REFRESH_INTERVAL(RI), .MAX_OWED(MAX)) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .refresh_hint (refresh_hint),
    .rq           (ri),
    .mem          (mi)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  logic [2:0]    r_we;
  logic [AB-1:0] r_addr  [3];
  logic [15:0]   r_wdata [3];
  logic [1:0]    r_wmask [3];

  function automatic int lowest(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] onehot(input int i);
    return 3'b001 << i;
  endfunction

  task automatic step();
    @(posedge clk);
    edge_n++;
    @(negedge clk);
  endtask

  task automatic pack_reqs();
    ri.we = r_we;
    for (int i = 0; i < 3; i++) begin
      ri.addr[i*AB +: AB]  = r_addr[i];
      ri.wdata[i*16 +: 16] = r_wdata[i];
      ri.wmask[i*2 +: 2]   = r_wmask[i];
    end
  endtask

  task automatic new_req(input int ch, input logic wr);
    r_we[ch]    = wr;
    r_addr[ch]  = AB'($urandom);
    r_wdata[ch] = 16'($urandom);
    r_wmask[ch] = 2'($urandom);
    pack_reqs();
    ri.req[ch] = 1'b1;
  endtask

  task automatic clear_inputs();
    ri.req = '0; ri.we = '0; ri.addr = '0; ri.wdata = '0; ri.wmask = '0;
    r_we = '0;
    for (int i = 0; i < 3; i++) begin
      r_addr[i] = '0; r_wdata[i] = '0; r_wmask[i] = '0;
    end
    mi.mem_ready = 1'b0; mi.mem_rvalid = 1'b0; mi.mem_rdata = '0;
    refresh_hint = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    async_nreset = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    async_nreset = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1 async_nreset = 1'b0;
    #1;
    n_cmp++;
    if ({ri.ack, ri.rvalid, ri.rdata} !== '0) begin
      n_fail++; $display("FAIL reset_req_side: got %h need 0", {ri.ack, ri.rvalid, ri.rdata});
    end
    n_cmp++;
    if ({mi.mem_req, mi.mem_refresh, mi.mem_we, mi.mem_addr, mi.mem_wdata, mi.mem_wmask} !== '0) begin
      n_fail++; $display("FAIL reset_mem_side: got %h need 0",
                         {mi.mem_req, mi.mem_refresh, mi.mem_we, mi.mem_addr, mi.mem_wdata, mi.mem_wmask});
    end
    do_reset();
    step(); step();
    n_cmp++;
    if ({mi.mem_req, mi.mem_refresh, ri.ack} !== '0) begin
      n_fail++; $display("FAIL reset_idle_quiet: got %b need 0", {mi.mem_req, mi.mem_refresh, ri.ack});
    end
  endtask

  task automatic test_read_ch1();
    do_reset();
    mi.mem_ready = 1'b1;
    new_req(1, 1'b0);
    step();
    n_cmp++;
    if (mi.mem_req !== 1'b1 || mi.mem_we !== 1'b0 || mi.mem_addr !== r_addr[1] || ri.ack !== 3'b000) begin
      n_fail++; $display("FAIL rd_issue: got req=%b we=%b addr=%h ack=%b need 1 0 %h 000",
                         mi.mem_req, mi.mem_we, mi.mem_addr, ri.ack, r_addr[1]);
    end
    step();
    n_cmp++;
    if (ri.ack !== 3'b010 || mi.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL rd_ack: got ack=%b req=%b need 010 0", ri.ack, mi.mem_req);
    end
    ri.req = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (ri.rvalid !== 3'b000) begin
        n_fail++; $display("FAIL rd_early_rvalid: got %b need 000", ri.rvalid);
      end
    end
    mi.mem_rvalid = 1'b1; mi.mem_rdata = 16'hBEEF;
    step();
    mi.mem_rvalid = 1'b0; mi.mem_rdata = '0;
    n_cmp++;
    if (ri.rvalid !== 3'b010 || ri.rdata !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_data: got rvalid=%b rdata=%h need 010 beef", ri.rvalid, ri.rdata);
    end
    step();
    n_cmp++;
    if (ri.rvalid !== 3'b000) begin
      n_fail++; $display("FAIL rd_rvalid_pulse: got %b need 000", ri.rvalid);
    end
  endtask

  task automatic test_priority();
    int exp_ch;
    bit seen;
    do_reset();
    mi.mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) new_req(c, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_ch = lowest(ri.req);
      seen = 0;
      for (int t = 0; t < 8 && !seen; t++) begin
        step();
        seen = mi.mem_req;
      end
      n_cmp++;
      if (!seen) begin
        n_fail++; $display("FAIL prio_grant_timeout: grant %0d got none need ch%0d", k, exp_ch);
      end else if (mi.mem_addr !== r_addr[exp_ch] || mi.mem_wdata !== r_wdata[exp_ch] ||
                   mi.mem_wmask !== r_wmask[exp_ch] || mi.mem_we !== 1'b1) begin
        n_fail++; $display("FAIL prio_fields: got addr=%h wdata=%h mask=%b need ch%0d %h %h %b",
                           mi.mem_addr, mi.mem_wdata, mi.mem_wmask, exp_ch,
                           r_addr[exp_ch], r_wdata[exp_ch], r_wmask[exp_ch]);
      end
      step();
      n_cmp++;
      if (ri.ack !== onehot(exp_ch)) begin
        n_fail++; $display("FAIL prio_ack: got %b need %b", ri.ack, onehot(exp_ch));
      end
      ri.req[exp_ch] = 1'b0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    new_req(2, 1'b1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (mi.mem_req !== 1'b1 || mi.mem_addr !== r_addr[2] || mi.mem_wdata !== r_wdata[2] ||
          mi.mem_wmask !== r_wmask[2] || mi.mem_we !== 1'b1 || ri.ack !== 3'b000) begin
        n_fail++; $display("FAIL stall_hold: cycle %0d got req=%b addr=%h wdata=%h ack=%b need 1 %h %h 000",
                           i, mi.mem_req, mi.mem_addr, mi.mem_wdata, ri.ack, r_addr[2], r_wdata[2]);
      end
    end
    mi.mem_ready = 1'b1;
    step();
    n_cmp++;
    if (ri.ack !== 3'b100 || mi.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL stall_ack: got ack=%b req=%b need 100 0", ri.ack, mi.mem_req);
    end
    ri.req = '0;
  endtask

  task automatic test_hint_refresh();
    int early;
    do_reset();
    mi.mem_ready = 1'b1;
    step(); step(); step(); step();
    refresh_hint = 1'b1;
    step();
    refresh_hint = 1'b0;
    early = 0;
    while (edge_n < 16) begin
      step();
      if (mi.mem_refresh) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++; $display("FAIL hint_owed_zero: got %0d refresh cycles need 0", early);
    end
    refresh_hint = 1'b1;
    new_req(0, 1'b1);
    step();
    refresh_hint = 1'b0;
    n_cmp++;
    if (mi.mem_refresh !== 1'b1 || mi.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL hint_refresh_first: got ref=%b req=%b need 1 0", mi.mem_refresh, mi.mem_req);
    end
    step();
    n_cmp++;
    if (mi.mem_refresh !== 1'b0 || mi.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL hint_refresh_done: got ref=%b req=%b need 0 0", mi.mem_refresh, mi.mem_req);
    end
    step();
    n_cmp++;
    if (mi.mem_req !== 1'b1 || mi.mem_addr !== r_addr[0]) begin
      n_fail++; $display("FAIL hint_then_ch0: got req=%b addr=%h need 1 %h", mi.mem_req, mi.mem_addr, r_addr[0]);
    end
    step();
    n_cmp++;
    if (ri.ack !== 3'b001) begin
      n_fail++; $display("FAIL hint_ch0_ack: got %b need 001", ri.ack);
    end
    ri.req = '0;
  endtask

  task automatic test_forced_refresh();
    int early;
    do_reset();
    early = 0;
    while (edge_n < MAX * RI) begin
      step();
      if (mi.mem_refresh || mi.mem_req) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++; $display("FAIL force_early: got %0d busy cycles before debt full need 0", early);
    end
    step();
    n_cmp++;
    if (mi.mem_refresh !== 1'b1) begin
      n_fail++; $display("FAIL force_assert: got %b need 1 at edge %0d", mi.mem_refresh, edge_n);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (mi.mem_refresh !== 1'b1 || mi.mem_req !== 1'b0) begin
        n_fail++; $display("FAIL force_hold: got ref=%b req=%b need 1 0", mi.mem_refresh, mi.mem_req);
      end
    end
    mi.mem_ready = 1'b1;
    step();
    n_cmp++;
    if (mi.mem_refresh !== 1'b0) begin
      n_fail++; $display("FAIL force_accept: got %b need 0", mi.mem_refresh);
    end
    // Debt is now MAX-1; the next wrap must force a refresh one edge later.
    early = 0;
    while (edge_n < (MAX + 1) * RI) begin
      step();
      if (mi.mem_refresh) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_fail++; $display("FAIL force_owed7_quiet: got %0d refresh cycles need 0", early);
    end
    step();
    n_cmp++;
    if (mi.mem_refresh !== 1'b1) begin
      n_fail++; $display("FAIL force_owed7_again: got %b need 1", mi.mem_refresh);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    do_reset();
    mi.mem_ready = 1'b1;
    new_req(0, 1'b0);
    step();
    step();
    ri.req = '0;
    step();
    #2 async_nreset = 1'b0;
    #1;
    n_cmp++;
    if ({mi.mem_req, mi.mem_refresh, mi.mem_we, mi.mem_addr, mi.mem_wdata, mi.mem_wmask,
         ri.ack, ri.rvalid, ri.rdata} !== '0) begin
      n_fail++; $display("FAIL midreset_clear: got addr=%h wdata=%h need all zero", mi.mem_addr, mi.mem_wdata);
    end
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    async_nreset = 1'b1;
    edge_n = 0;
    mi.mem_ready = 1'b1;
    new_req(2, 1'b0);
    step();
    n_cmp++;
    if (mi.mem_req !== 1'b1 || mi.mem_addr !== r_addr[2]) begin
      n_fail++; $display("FAIL midreset_ch2_issue: got req=%b addr=%h need 1 %h", mi.mem_req, mi.mem_addr, r_addr[2]);
    end
    step();
    n_cmp++;
    if (ri.ack !== 3'b100) begin
      n_fail++; $display("FAIL midreset_ch2_ack: got %b need 100", ri.ack);
    end
    ri.req = '0;
    d = 16'($urandom);
    mi.mem_rvalid = 1'b1; mi.mem_rdata = d;
    step();
    mi.mem_rvalid = 1'b0;
    n_cmp++;
    if (ri.rvalid !== 3'b100 || ri.rdata !== d) begin
      n_fail++; $display("FAIL midreset_ch2_data: got rvalid=%b rdata=%h need 100 %h", ri.rvalid, ri.rdata, d);
    end
  endtask

  task automatic test_random();
    int owed_m, owed_before, cur_owner, rd_owner, rd_cnt, stall, maxed, exp_o;
    bit rd_pending;
    logic [2:0] s_req, exp_ack, exp_rv;
    logic s_hint, s_mreq, s_mref, s_ready, s_rv, s_we;
    logic [15:0] s_rdata;
    do_reset();
    owed_m = 0; cur_owner = 0; rd_owner = 0; rd_cnt = 0; stall = 0; maxed = 0; rd_pending = 0;
    mi.mem_ready = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_req = ri.req; s_hint = refresh_hint; s_mreq = mi.mem_req; s_mref = mi.mem_refresh;
      s_ready = mi.mem_ready; s_rv = mi.mem_rvalid; s_rdata = mi.mem_rdata; s_we = mi.mem_we;
      owed_before = owed_m;
      @(posedge clk);
      edge_n++;
      owed_m = owed_m + ((edge_n % RI == 0) ? 1 : 0) - ((s_mref && s_ready) ? 1 : 0);
      if (owed_m > MAX) owed_m = MAX;
      @(negedge clk);

      exp_rv = s_rv ? onehot(rd_owner) : 3'b000;
      n_cmp++;
      if (ri.rvalid !== exp_rv || (s_rv && ri.rdata !== s_rdata)) begin
        n_fail++; $display("FAIL rnd_rvalid: cyc %0d got %b/%h need %b/%h", cyc, ri.rvalid, ri.rdata, exp_rv, s_rdata);
      end
      if (s_rv) rd_pending = 0;

      exp_ack = (s_mreq && s_ready) ? onehot(cur_owner) : 3'b000;
      n_cmp++;
      if (ri.ack !== exp_ack) begin
        n_fail++; $display("FAIL rnd_ack: cyc %0d got %b need %b", cyc, ri.ack, exp_ack);
      end
      if (s_mreq && s_ready && !s_we) begin
        rd_pending = 1; rd_owner = cur_owner; rd_cnt = $urandom_range(0, 3);
      end

      n_cmp++;
      if (mi.mem_req && mi.mem_refresh) begin
        n_fail++; $display("FAIL rnd_exclusive: cyc %0d got req=1 ref=1 need at most one", cyc);
      end

      if (mi.mem_req && !s_mreq) begin
        exp_o = lowest(s_req);
        n_cmp++;
        if (exp_o < 0) begin
          n_fail++; $display("FAIL rnd_grant_noreq: cyc %0d got grant need none", cyc);
        end else if (mi.mem_addr !== r_addr[exp_o] || mi.mem_we !== r_we[exp_o] ||
                     mi.mem_wdata !== r_wdata[exp_o] || mi.mem_wmask !== r_wmask[exp_o]) begin
          n_fail++; $display("FAIL rnd_grant_fields: cyc %0d got addr=%h we=%b need ch%0d addr=%h we=%b",
                             cyc, mi.mem_addr, mi.mem_we, exp_o, r_addr[exp_o], r_we[exp_o]);
        end
        cur_owner = (exp_o < 0) ? 0 : exp_o;
      end

      if (mi.mem_refresh && !s_mref) begin
        n_cmp++;
        if (!(owed_before == MAX || (s_hint && owed_before > 0))) begin
          n_fail++; $display("FAIL rnd_refresh_cause: cyc %0d got refresh need none (owed=%0d hint=%b)",
                             cyc, owed_before, s_hint);
        end
      end

      maxed = (owed_m == MAX) ? maxed + 1 : 0;
      n_cmp++;
      if (maxed > 20) begin
        n_fail++; $display("FAIL rnd_force_late: cyc %0d got debt full for %0d cycles need <=20", cyc, maxed);
      end

      for (int ch = 0; ch < 3; ch++) begin
        if (ri.ack[ch]) begin
          if ($urandom_range(0, 2) == 0) new_req(ch, 1'($urandom));
          else ri.req[ch] = 1'b0;
        end else if (!ri.req[ch] && $urandom_range(0, 3) == 0) begin
          new_req(ch, 1'($urandom));
        end
      end
      mi.mem_ready = (stall >= 4) ? 1'b1 : ($urandom_range(0, 2) != 0);
      stall = mi.mem_ready ? 0 : stall + 1;
      mi.mem_rvalid = 1'b0;
      if (rd_pending) begin
        if (rd_cnt == 0) begin
          mi.mem_rvalid = 1'b1; mi.mem_rdata = 16'($urandom);
        end else begin
          rd_cnt--;
        end
      end
      refresh_hint = ($urandom_range(0, 9) == 0);
    end
    clear_inputs();
  endtask

  initial begin
    async_nreset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    test_reset();
    test_read_ch1();
    test_priority();
    test_stall();
    test_hint_refresh();
    test_forced_refresh();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion need finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sdram_sched.md
Name: sdram_sched

Overview:
- Scheduler between the three SDRAM requester channels (ch0 CPU/PRG, ch1 PPU/CHR, ch2 API) and the single command port of the SDRAM controller.
- Arbitrates requests with fixed priority and keeps exactly one access outstanding.
- Routes read data back to the channel that owns the access.
- Owns refresh scheduling: a refresh is issued opportunistically on the M2-derived hint pulse, or forced when the owed-refresh count reaches its limit.

Parameters:
- ADDR_BITS, 22: SDRAM word address width (row + col + bank).
- REFRESH_INTERVAL, 780: clk cycles per owed refresh.
- MAX_OWED, 8: owed-refresh count at which a refresh is forced; the counter saturates here.

Ports:
- clk  in  1: system clock.
- async_nreset  in  1: reset, asynchronous, active-low.
- req  in  3: request per channel; held high until the matching ack.
- we  in  3: 1 = write, per channel.
- addr  in  3*ADDR_BITS: channel i at [i*ADDR_BITS +: ADDR_BITS].
- wdata  in  48: channel i at [i*16 +: 16].
- wmask  in  6: byte mask, channel i at [i*2 +: 2].
- ack  out  3: one-cycle pulse when the channel's command is accepted by the controller.
- rvalid  out  3: one-cycle pulse with read data for the owning channel.
- rdata  out  16: read data, shared by all channels; valid only with rvalid.
- refresh_hint  in  1: one-cycle pulse, the safe slot after the M2 OE cycle.
- mem_req  out  1: access command valid.
- mem_refresh  out  1: refresh command valid.
- mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_BITS/16/2: command fields.
- mem_ready  in  1: controller accepts the command in any cycle where it is high together with mem_req or mem_refresh.
- mem_rvalid  in  1: read data return pulse.
- mem_rdata  in  16: read data.

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; interval counter 0; owed 0; owner 0.
- Interval counter:
  - Increments every cycle.
  - At REFRESH_INTERVAL-1 it wraps to 0 and owed increments, saturating at MAX_OWED.
  - An increment and a refresh issue in the same cycle leave owed unchanged.
- States: IDLE, ISSUE, RD_WAIT, REF.
- IDLE decision, evaluated each cycle, first true condition wins:
  1. owed == MAX_OWED → REF (forced, overrides all channels).
  2. refresh_hint && owed > 0 → REF.
  3. Lowest-index channel with req high → ISSUE. Latch owner, we, addr, wdata and wmask from that channel; drive mem_req = 1 on the next cycle.
  4. Otherwise stay in IDLE.
- ISSUE:
  - Hold mem_req and all fields stable until a cycle with mem_ready = 1. That cycle is acceptance.
  - On acceptance: ack[owner] pulses in the following cycle and mem_req drops.
  - Then go to RD_WAIT if the access is a read, otherwise back to IDLE.
- RD_WAIT:
  - On mem_rvalid: rdata ← mem_rdata, rvalid[owner] pulses the next cycle, go to IDLE.
  - No new command is issued while in RD_WAIT.
- REF:
  - Hold mem_refresh until mem_ready. On acceptance, owed decrements and the state returns to IDLE.
  - No ack or rvalid is generated for a refresh.
- A refresh_hint that arrives outside IDLE is dropped; the refresh is not deferred to a later hint.
- Latency, idle controller with mem_ready = 1: req at cycle 0 → mem_req at cycle 1 → ack at cycle 2.
- ack and rvalid are one-hot or zero, and never asserted for a channel that is not the owner.
- mem_req and mem_refresh are never high in the same cycle.
- Requester rules:
  - A requester may raise req in the same cycle its ack arrives, to request back-to-back.
  - Dropping req before ack is illegal; the scheduler ignores the drop and completes the latched access.
- Starvation: fixed priority is intentional. Lower-priority channels are served in the gaps between CPU/PPU bus cycles.
- Reset asserted mid-access: abort immediately, no ack; the controller is reset by the same source.

Test Plan:
- Read on ch1, mem_ready = 1, mem_rvalid 3 cycles after acceptance with mem_rdata = 0xBEEF → mem_req at cycle 1, ack = 3'b010 at cycle 2, rvalid = 3'b010 with rdata = 0xBEEF.
- req = 3'b111, all writes, mem_ready always 1 → grants in order ch0, ch1, ch2; ack one-hot each time; mem_addr matches the granted slice.
- REFRESH_INTERVAL = 16, no hints, no requests → owed reaches MAX_OWED = 8 at cycle 128 → mem_refresh asserted; owed becomes 7 after acceptance.
- owed = 1 and refresh_hint together with ch0 req in IDLE → refresh issued first, ch0 mem_req follows.
- mem_ready low for 5 cycles during ISSUE → mem_req and fields stable throughout; ack only after mem_ready rises.
- async_nreset low during RD_WAIT → all outputs 0 immediately; after release, a new ch2 request completes normally.
